if_stage: RTL and testbench
===========================

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC loaded on reset (bits [1:0] SHALL be 0).
REQ-002 Parameter DEPTH, default 8, fetch-queue entries; legal values SHALL be powers of 2, minimum 4.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 imem_req  output  1  fetch request; accepted in the cycle it is high.
REQ-006 imem_addr  output  32  fetch address, always 8-byte aligned.
REQ-007 imem_valid  input  1  response strobe; in order, at least 1 cycle after the request.
REQ-008 imem_rdata1 / imem_rdata2  input  32 each  words at imem_addr and imem_addr+4.
REQ-009 stall  input  1  ID cannot accept; outputs SHALL hold.
REQ-010 redirect  input  1  flush and refetch from redirect_pc.
REQ-011 redirect_pc  input  32  new PC; bits [1:0] SHALL be ignored (treated as 0).
REQ-012 instr1 / instr2  output  32 each  slot A and slot B instructions to ID (A is older).
REQ-013 pc1 / pc2  output  32 each  PCs of instr1 / instr2.
REQ-014 valid1 / valid2  output  1 each  slot valid; valid2 SHALL never be 1 while valid1 is 0.

Function
REQ-015 Fetch FSM states: REQ (may issue), WAIT (one request outstanding), DROP (one request outstanding, response to be discarded).
REQ-016 imem_req SHALL equal (state==REQ) && (free entries >= 2) && !redirect; free entries SHALL be computed from the registered count.
REQ-017 imem_addr SHALL be {pc[31:3],3'b000}; on issue: pc <= {pc[31:3],3'b000}+8, and the FSM SHALL go REQ->WAIT.
REQ-018 In WAIT on imem_valid: if the issuing PC had bit 2 = 0, the queue SHALL enqueue (rdata1, addr) and then (rdata2, addr+4); if bit 2 = 1, it SHALL enqueue only (rdata2, addr+4). The FSM SHALL then go WAIT->REQ.
REQ-019 A request SHALL be issued no earlier than the cycle after the response completes, so at most one request is outstanding.
REQ-020 Output registers: when !stall, slot A SHALL load the queue head and slot B head+1, each only if present; the head SHALL advance by the number loaded (0, 1 or 2). Enqueue and dequeue in the same cycle SHALL both take effect.
REQ-021 An empty slot SHALL output instr=32'h0000_0013 (NOP), pc=0, valid=0.
REQ-022 When stall=1 and redirect=0: outputs and the head pointer SHALL hold; enqueue SHALL continue while space exists.
REQ-023 Redirect SHALL have top priority, including over stall. On the next edge:
  - queue empty;
  - both slots NOP with valid=0;
  - pc <= {redirect_pc[31:2],2'b00};
  - WAIT->DROP, REQ stays REQ, DROP stays DROP.
REQ-024 In DROP, imem_valid SHALL write nothing and the FSM SHALL go DROP->REQ.
REQ-025 Queue pointers SHALL wrap modulo DEPTH; the count SHALL range 0..DEPTH and never overflow, guaranteed by REQ-016.
REQ-026 Redirect and imem_valid in the same cycle: the response SHALL be discarded and the FSM SHALL go to REQ.

Reset
REQ-027 While rst_n=0, without waiting for a clock edge:
  - pc=RESET_PC; queue empty; state REQ;
  - imem_req=0;
  - instr1/instr2=NOP; pc1/pc2=0; valid1/valid2=0.
REQ-028 Asserting rst_n mid-operation SHALL abandon any outstanding request; after release, a late imem_valid SHALL be ignored until a new request has issued.

Verification
REQ-029 Release reset, RESET_PC=0, memory returns data = address, 1-cycle latency, stall=0 -> first issue has imem_addr=0; two cycles after the response, instr1=0/pc1=0, instr2=4/pc2=4, both valid.
REQ-030 Hold stall=1 for 12 cycles after reset, DEPTH=8 -> queue reaches 8 entries; imem_req stays 0 once free<2; outputs are stable; on stall release, pairs emerge in PC order 0,4,8,...
REQ-031 Redirect to 0x104 -> next imem_addr=0x100, one entry enqueued; first output pc1=0x104 (valid2 may be 0), followed by pairs 0x108/0x10C.
REQ-032 Redirect to 0x200 while in WAIT -> the stale response (addr 0x40) is dropped; no output ever carries pc 0x40 or 0x44; the next issue has addr 0x200.
REQ-033 Redirect and stall together with a full queue -> next cycle valid1=valid2=0, queue empty; stall is ignored for the flush.
REQ-034 Assert rst_n=0 between clock edges while valid1=1 -> valid1, valid2 and imem_req are 0 immediately; after release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/if_stage.sv
// if_stage: instruction fetch for a dual-issue front end.
// Issues one 8-byte-aligned fetch at a time and queues the returned words with
// their PCs. Each cycle it offers the two oldest queued instructions to ID.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   imem_req, imem_addr        fetch request and aligned address
//   imem_valid, imem_rdata1/2  in-order response: words at addr and addr+4
//   stall                      ID cannot accept; output slots hold
//   redirect, redirect_pc      flush everything and refetch from redirect_pc
//   instr1/2, pc1/2, valid1/2  slot A (older) and slot B to ID
//
// state  | meaning
// S_REQ  | idle, may issue a fetch
// S_WAIT | one fetch outstanding, response is kept
// S_DROP | one fetch outstanding, response is discarded (flushed by redirect)
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata1,
  input  logic [31:0] imem_rdata2,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] instr1,
  output logic [31:0] instr2,
  output logic [31:0] pc1,
  output logic [31:0] pc2,
  output logic        valid1,
  output logic        valid2
);

  localparam int          AW  = $clog2(DEPTH);
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_DROP} state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] req_addr;
  logic        req_hi;
  logic [AW-1:0] head, tail;
  logic [AW:0]   count;
  logic [31:0] q_instr [DEPTH];
  logic [31:0] q_pc    [DEPTH];

  logic [31:0]   pc_al, rpc_al;
  logic [AW:0]   free;
  logic [AW-1:0] head1, tail1;
  logic          has1, has2, enq_ok;
  logic [1:0]    n_deq, n_enq;

  assign pc_al  = pc & 32'hFFFF_FFF8;
  assign rpc_al = redirect_pc & 32'hFFFF_FFFC;
  assign free   = (AW+1)'(DEPTH) - count;
  assign head1  = head + AW'(1);
  assign tail1  = tail + AW'(1);
  assign has1   = (count != '0);
  assign has2   = (count >= (AW+1)'(2));

  // Gated by rst_n so the request drops immediately on reset assertion.
  assign imem_req  = rst_n && (state == S_REQ) && (free >= (AW+1)'(2)) && !redirect;
  assign imem_addr = pc_al;

  // A response arriving together with a redirect belongs to the old stream.
  assign enq_ok = (state == S_WAIT) && imem_valid && !redirect;

  always_comb begin
    n_enq = 2'd0;
    if (enq_ok) n_enq = req_hi ? 2'd1 : 2'd2;
    n_deq = 2'd0;
    if (!stall) n_deq = has2 ? 2'd2 : (has1 ? 2'd1 : 2'd0);
  end

  // Queue storage needs no reset: occupancy is tracked by count.
  always_ff @(posedge clk) begin
    if (enq_ok) begin
      if (req_hi) begin
        q_instr[tail] <= imem_rdata2;
        q_pc[tail]    <= req_addr + 32'd4;
      end else begin
        q_instr[tail]  <= imem_rdata1;
        q_pc[tail]     <= req_addr;
        q_instr[tail1] <= imem_rdata2;
        q_pc[tail1]    <= req_addr + 32'd4;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_REQ;
      pc       <= RESET_PC;
      req_addr <= '0;
      req_hi   <= 1'b0;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      instr1   <= NOP;
      instr2   <= NOP;
      pc1      <= '0;
      pc2      <= '0;
      valid1   <= 1'b0;
      valid2   <= 1'b0;
    end else begin
      case (state)
        S_REQ:   if (imem_req) state <= S_WAIT;
        S_WAIT:  if (imem_valid) state <= S_REQ;
                 else if (redirect) state <= S_DROP;
        S_DROP:  if (imem_valid) state <= S_REQ;
        default: state <= S_REQ;
      endcase

      if (redirect) begin
        pc <= rpc_al;
      end else if (imem_req) begin
        pc       <= pc_al + 32'd8;
        req_addr <= pc_al;
        req_hi   <= pc[2];
      end

      if (redirect) begin
        head   <= '0;
        tail   <= '0;
        count  <= '0;
        instr1 <= NOP;
        instr2 <= NOP;
        pc1    <= '0;
        pc2    <= '0;
        valid1 <= 1'b0;
        valid2 <= 1'b0;
      end else begin
        head  <= head + AW'(n_deq);
        tail  <= tail + AW'(n_enq);
        count <= count + (AW+1)'(n_enq) - (AW+1)'(n_deq);
        if (!stall) begin
          instr1 <= has1 ? q_instr[head]  : NOP;
          pc1    <= has1 ? q_pc[head]     : 32'h0;
          valid1 <= has1;
          instr2 <= has2 ? q_instr[head1] : NOP;
          pc2    <= has2 ? q_pc[head1]    : 32'h0;
          valid2 <= has2;
        end
      end
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios plus randomized stall/redirect/latency,
// compared every cycle against a queue-based reference of the fetch stream.
module tb_if_stage;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 8;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk, rst_n;
  logic        imem_req, imem_valid;
  logic [31:0] imem_addr, imem_rdata1, imem_rdata2;
  logic        stall, redirect;
  logic [31:0] redirect_pc;
  logic [31:0] instr1, instr2, pc1, pc2;
  logic        valid1, valid2;

  if_stage #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_valid(imem_valid), .imem_rdata1(imem_rdata1), .imem_rdata2(imem_rdata2),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .instr1(instr1), .instr2(instr2), .pc1(pc1), .pc2(pc2),
    .valid1(valid1), .valid2(valid2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
  endtask

  // memory content: a fixed scramble of the address
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  // reference model: program-order list of PCs waiting in the fetch queue
  logic [31:0] mq[$];
  logic [31:0] m_pc, m_issue;
  int          m_out;          // 0 idle, 1 live request, 2 request to discard
  logic [31:0] e_pc1, e_pc2;
  logic        e_v1, e_v2;

  // memory responder
  bit          mem_busy;
  int          mem_wait;
  int          lat;            // 0 = random 1..3
  logic [31:0] mem_addr;

  logic        last_req;
  logic [31:0] last_addr;

  task automatic model_reset();
    mq.delete();
    m_pc  = RESET_PC;
    m_out = 0;
    e_v1 = 1'b0; e_v2 = 1'b0; e_pc1 = '0; e_pc2 = '0;
  endtask

  task automatic check_outs();
    check_eq("valid1", valid1, e_v1);
    check_eq("valid2", valid2, e_v2);
    check_eq("pc1", pc1, e_pc1);
    check_eq("pc2", pc2, e_pc2);
    check_eq("instr1", instr1, e_v1 ? mem_word(e_pc1) : NOP);
    check_eq("instr2", instr2, e_v2 ? mem_word(e_pc2) : NOP);
  endtask

  task automatic step(input bit s, input bit r, input logic [31:0] rp);
    bit exp_req;
    @(negedge clk);
    stall       = s;
    redirect    = r;
    redirect_pc = rp;
    imem_valid  = mem_busy && (mem_wait == 0);
    imem_rdata1 = mem_word(mem_addr);
    imem_rdata2 = mem_word(mem_addr + 32'd4);
    #1;
    exp_req = (m_out == 0) && ((DEPTH - mq.size()) >= 2) && !r;
    check_eq("imem_req", imem_req, exp_req);
    if (exp_req) check_eq("imem_addr", imem_addr, m_pc & 32'hFFFF_FFF8);
    last_req  = imem_req;
    last_addr = imem_addr;
    @(posedge clk);
    if (r) begin
      mq.delete();
      e_v1 = 1'b0; e_v2 = 1'b0; e_pc1 = '0; e_pc2 = '0;
      m_pc = rp & 32'hFFFF_FFFC;
      if (m_out != 0) m_out = imem_valid ? 0 : 2;
    end else begin
      if (!s) begin
        e_v1  = (mq.size() >= 1);
        e_pc1 = e_v1 ? mq.pop_front() : 32'h0;
        e_v2  = e_v1 && (mq.size() >= 1);
        e_pc2 = e_v2 ? mq.pop_front() : 32'h0;
      end
      if (imem_valid && m_out == 1) begin
        if (!m_issue[2]) mq.push_back(m_issue & 32'hFFFF_FFF8);
        mq.push_back((m_issue & 32'hFFFF_FFF8) + 32'd4);
      end
      if (imem_valid) m_out = 0;
      if (exp_req) begin
        m_out   = 1;
        m_issue = m_pc;
        m_pc    = (m_pc & 32'hFFFF_FFF8) + 32'd8;
      end
    end
    if (imem_valid) mem_busy = 1'b0;
    else if (mem_busy) mem_wait--;
    if (last_req) begin
      mem_busy = 1'b1;
      mem_addr = last_addr;
      mem_wait = ((lat == 0) ? int'($urandom_range(1, 3)) : lat) - 1;
    end
    #1;
    check_outs();
  endtask

  // reset asserted between edges; outputs must clear without a clock edge
  task automatic do_reset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_imem_req", imem_req, 1'b0);
    check_eq("rst_valid1", valid1, 1'b0);
    check_eq("rst_valid2", valid2, 1'b0);
    check_eq("rst_instr1", instr1, NOP);
    check_eq("rst_pc2", pc2, 32'h0);
    model_reset();
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic wait_valid(input int budget);
    int k = 0;
    do begin
      step(1'b0, 1'b0, 32'h0);
      k++;
    end while (!valid1 && k < budget);
    check_eq("wait_valid", valid1, 1'b1);
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    imem_valid = 1'b0; imem_rdata1 = '0; imem_rdata2 = '0;
    mem_busy = 1'b0; mem_wait = 0; mem_addr = '0; lat = 1;
    last_req = 1'b0; last_addr = '0; m_issue = '0;
    model_reset();

    #12;
    check_eq("reset_req", imem_req, 1'b0);
    check_eq("reset_valid1", valid1, 1'b0);
    check_eq("reset_instr2", instr2, NOP);
    check_eq("reset_pc1", pc1, 32'h0);
    @(posedge clk);
    #2 rst_n = 1'b1;

    // first fetch, 1-cycle memory
    step(1'b0, 1'b0, 32'h0);
    check_eq("first_req", last_req, 1'b1);
    check_eq("first_addr", last_addr, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    check_eq("first_pc1", pc1, 32'h0);
    check_eq("first_pc2", pc2, 32'h4);
    check_eq("first_instr2", instr2, mem_word(32'h4));
    check_eq("first_v2", valid2, 1'b1);

    // stall fills the queue, then pairs drain in order
    do_reset();
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 32'h0);
    check_eq("full_req", last_req, 1'b0);
    check_eq("full_v1", valid1, 1'b0);
    step(1'b0, 1'b0, 32'h0);
    check_eq("drain_pc1a", pc1, 32'h0);
    check_eq("drain_pc2a", pc2, 32'h4);
    step(1'b0, 1'b0, 32'h0);
    check_eq("drain_pc1b", pc1, 32'h8);
    check_eq("drain_pc2b", pc2, 32'hC);

    // redirect to an odd word
    step(1'b0, 1'b1, 32'h0000_0104);
    step(1'b0, 1'b0, 32'h0);
    check_eq("rd104_addr", last_addr, 32'h100);
    wait_valid(20);
    check_eq("rd104_pc1", pc1, 32'h104);
    wait_valid(20);
    check_eq("rd104_pc1b", pc1, 32'h108);
    check_eq("rd104_pc2b", pc2, 32'h10C);

    // redirect while a fetch is outstanding; its response must be dropped
    lat = 3;
    step(1'b0, 1'b1, 32'h0000_0040);
    step(1'b0, 1'b0, 32'h0);
    check_eq("stale_addr", last_addr, 32'h40);
    step(1'b0, 1'b1, 32'h0000_0202);
    wait_valid(30);
    check_eq("after_drop_pc1", pc1, 32'h200);
    check_eq("after_drop_pc2", pc2, 32'h204);

    // redirect with stall and a full queue
    lat = 1;
    for (int i = 0; i < 14; i++) step(1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 32'h0000_0300);
    check_eq("flush_v1", valid1, 1'b0);
    check_eq("flush_v2", valid2, 1'b0);
    step(1'b1, 1'b0, 32'h0);
    check_eq("flush_req", last_req, 1'b1);
    check_eq("flush_addr", last_addr, 32'h300);

    // mid-operation reset while slot A is valid
    wait_valid(20);
    do_reset();
    step(1'b0, 1'b0, 32'h0);
    check_eq("restart_addr", last_addr, RESET_PC);

    // randomized traffic
    lat = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) do_reset();
      step($urandom_range(0, 9) < 3, $urandom_range(0, 39) == 0, $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
